// File: rtl/ysyx_22040125_ram_arb.sv
// ysyx_22040125_ram_arb: shares a single-port 64-bit RAM between IFU (m0) and LSU (m1), doing RMW for partial stores.
// Define YSYX_22040125_ARB_FIXED_PRIO_EN to make m1 always win ties instead of round-robin.
module ysyx_22040125_ram_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_W-1:0]     m0_addr,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic                  m1_we,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [31:0]           ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_wen,
  input  logic [DATA_W-1:0]     ram_rdata
);
  localparam int STRB_W = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, RD_RESP, RMW_MERGE, WR_RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, merged;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic g0, g1, idle, wen_c;
  assign idle = state_q == IDLE;
`ifdef YSYX_22040125_ARB_FIXED_PRIO_EN
  assign g1 = m1_valid;
  assign g0 = m0_valid && !m1_valid;
`else
  logic last_q, last_d;
  assign g0 = m0_valid && (!m1_valid || last_q);
  assign g1 = m1_valid && !g0;
  assign last_d = (idle && (g0 || g1)) ? g1 : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else last_q <= last_d;
`endif
  assign m0_ready = idle && g0 && rst_n;
  assign m1_ready = idle && g1 && rst_n;
  assign ram_wen = wen_c && rst_n;
  for (genvar i = 0; i < STRB_W; i++) begin : g_merge
    assign merged[8*i+:8] = wstrb_q[i] ? wdata_q[8*i+:8] : ram_rdata[8*i+:8];
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    wen_c = 1'b0;
    ram_addr = 32'(addr_q);
    ram_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        ram_addr = 32'(g1 ? m1_addr : m0_addr);
        ram_wdata = g1 ? m1_wdata : '0;
        wen_c = g1 && m1_we && &m1_wstrb;
        if (g0 || g1) begin
          owner_d = g1;
          addr_d = g1 ? m1_addr : m0_addr;
          wdata_d = g1 ? m1_wdata : '0;
          wstrb_d = g1 ? m1_wstrb : '0;
          state_d = !(g1 && m1_we) ? RD_RESP : (m1_wstrb == '0 || &m1_wstrb) ? WR_RESP : RMW_MERGE;
        end
      end
      RD_RESP: begin
        m0_rvalid = !owner_q;
        m1_rvalid = owner_q;
        m0_rdata = owner_q ? '0 : ram_rdata;
        m1_rdata = owner_q ? ram_rdata : '0;
        state_d = IDLE;
      end
      RMW_MERGE: begin
        wen_c = 1'b1;
        ram_wdata = merged;
        state_d = WR_RESP;
      end
      WR_RESP: begin
        m1_rvalid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
endmodule

// File: tb/tb_ysyx_22040125_ram_arb.sv
// tb_ysyx_22040125_ram_arb: random and directed traffic against a transaction-level model of the arbiter and RAM.
module tb_ysyx_22040125_ram_arb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_valid, m0_ready, m0_rvalid, m1_valid, m1_ready, m1_we, m1_rvalid, ram_wen;
  logic [31:0] m0_addr, m1_addr, ram_addr;
  logic [63:0] m0_rdata, m1_wdata, m1_rdata, ram_wdata, ram_rdata;
  logic [7:0] m1_wstrb;
  always #5 clk = ~clk;
  ysyx_22040125_ram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
  );
  logic [63:0] mem [256];
  logic pl_en = 1'b0;
  logic [7:0] pl_addr;
  logic [63:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wen) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end
  logic [63:0] sh [256];
  int cyc = 0, resp_cyc = -1, resp_who = 0, wr_cyc = -1, free_cyc = 0;
  int acc_cyc = 0, rv_cyc0 = 0, rv_cyc1 = 0, ncmp = 0, nerr = 0;
  logic [7:0] wr_addr;
  logic [63:0] wr_val, resp_data, last_rd0, last_rd1;
  bit last = 1'b1;
  int gq[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    bit e0, e1, ew;
    int g;
    logic [7:0] a;
    if (!rst_n) begin
      chk("rst_m0_ready", m0_ready, 0);
      chk("rst_m1_ready", m1_ready, 0);
      chk("rst_ram_wen", ram_wen, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      resp_cyc = -1; wr_cyc = -1; free_cyc = 0; last = 1'b1;
    end else begin
      e0 = 0; e1 = 0; g = 0;
      if (cyc >= free_cyc && (m0_valid || m1_valid)) begin
`ifdef YSYX_22040125_ARB_FIXED_PRIO_EN
        g = m1_valid ? 1 : 0;
`else
        g = (m0_valid && m1_valid) ? (last ? 0 : 1) : (m1_valid ? 1 : 0);
`endif
        e0 = g == 0; e1 = g == 1;
      end
      chk("m0_ready", m0_ready, e0);
      chk("m1_ready", m1_ready, e1);
      ew = cyc == wr_cyc;
      if (e0 || e1) begin
        gq.push_back(g);
        last = g[0];
        acc_cyc = cyc;
        a = g ? m1_addr[7:0] : m0_addr[7:0];
        resp_who = g; resp_cyc = cyc + 1; resp_data = 0; free_cyc = cyc + 2;
        if (g == 0 || !m1_we) resp_data = sh[a];
        else if (&m1_wstrb) begin
          wr_cyc = cyc; wr_addr = a; wr_val = m1_wdata; ew = 1;
        end else if (m1_wstrb != 0) begin
          wr_cyc = cyc + 1; wr_addr = a;
          for (int b = 0; b < 8; b++) wr_val[8*b+:8] = m1_wstrb[b] ? m1_wdata[8*b+:8] : sh[a][8*b+:8];
          resp_cyc = cyc + 2; free_cyc = cyc + 3;
        end
      end
      chk("ram_wen", ram_wen, ew);
      if (ew) sh[wr_addr] = wr_val;
      chk("m0_rvalid", m0_rvalid, resp_cyc == cyc && resp_who == 0);
      chk("m1_rvalid", m1_rvalid, resp_cyc == cyc && resp_who == 1);
      if (resp_cyc == cyc && resp_who == 0) begin
        chk("m0_rdata", m0_rdata, resp_data);
        last_rd0 = m0_rdata; rv_cyc0 = cyc;
      end
      if (resp_cyc == cyc && resp_who == 1) begin
        chk("m1_rdata", m1_rdata, resp_data);
        last_rd1 = m1_rdata; rv_cyc1 = cyc;
      end
    end
  end
  task automatic wait_rdy(input bit who);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (who ? m1_ready : m0_ready) return;
    end
    ncmp++; nerr++;
    $display("FAIL ready_timeout m%0d: got no ready expected ready within 40 cycles", who);
  endtask
  task automatic do0(input logic [7:0] a);
    m0_valid = 1; m0_addr = {24'b0, a};
    wait_rdy(0);
    @(posedge clk); #1 m0_valid = 0;
  endtask
  task automatic do1(input logic [7:0] a, input bit we, input logic [63:0] wd, input logic [7:0] st);
    m1_valid = 1; m1_addr = {24'b0, a}; m1_we = we; m1_wdata = wd; m1_wstrb = st;
    wait_rdy(1);
    @(posedge clk); #1 m1_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic preload(input logic [7:0] a, input logic [63:0] d);
    pl_en = 1; pl_addr = a; pl_data = d; sh[a] = d;
    @(posedge clk); #1 pl_en = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1);
  end
  initial begin
    m0_valid = 1; m0_addr = 0; m1_valid = 0; m1_addr = 0; m1_we = 0; m1_wdata = 0; m1_wstrb = 0;
    for (int i = 0; i < 256; i++) sh[i] = 0;
    idle(2);
    chk("ready_in_reset", m0_ready, 0);
    m0_valid = 0; rst_n = 1;
    preload(8'h10, 64'h1122334455667788);
    preload(8'h30, 64'hFFFFFFFFFFFFFFFF);
    preload(8'h40, 64'h55);
    do0(8'h10); idle(2);
    chk("fetch_data", last_rd0, 64'h1122334455667788);
    chk("fetch_latency", rv_cyc0 - acc_cyc, 1);
    do1(8'h20, 1, 64'hDEADBEEFCAFEF00D, 8'hFF); idle(2);
    chk("store_latency", rv_cyc1 - acc_cyc, 1);
    chk("store_rdata", last_rd1, 0);
    do1(8'h20, 0, 0, 0); idle(2);
    chk("load_back", last_rd1, 64'hDEADBEEFCAFEF00D);
    do1(8'h30, 1, 0, 8'h0F); idle(3);
    chk("rmw_latency", rv_cyc1 - acc_cyc, 2);
    chk("rmw_ram", mem[8'h30], 64'hFFFFFFFF00000000);
    gq.delete();
    fork
      for (int i = 0; i < 4; i++) do0(8'(i));
      for (int i = 0; i < 4; i++) do1(8'(4 + i), 0, 0, 0);
    join
    idle(3);
`ifdef YSYX_22040125_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) chk("tie_grant", gq[i], 1);
`else
    for (int i = 0; i < 4; i++) chk("tie_grant", gq[i], i % 2);
`endif
    do1(8'h40, 1, 64'hFFFFFFFFFFFFFFFF, 8'h00); idle(2);
    chk("zstrb_latency", rv_cyc1 - acc_cyc, 1);
    chk("zstrb_ram", mem[8'h40], 64'h55);
    do1(8'h30, 1, 64'h0123456789ABCDEF, 8'hF0);
    rst_n = 0;
    @(negedge clk);
    chk("rmw_reset_wen", ram_wen, 0);
    @(posedge clk); #1 rst_n = 1; m0_valid = 1; m0_addr = 32'h30;
    @(negedge clk);
    chk("ready_after_reset", m0_ready, 1);
    @(posedge clk); #1 m0_valid = 0;
    idle(2);
    chk("rmw_dropped", last_rd0, 64'hFFFFFFFF00000000);
    fork
      repeat (60) begin
        idle($urandom_range(0, 2));
        do0(8'($urandom_range(0, 15)));
      end
      repeat (60) begin
        logic [7:0] st;
        int k;
        k = $urandom_range(0, 2);
        st = k == 0 ? 8'hFF : k == 1 ? 8'h00 : 8'($urandom);
        idle($urandom_range(0, 2));
        do1(8'($urandom_range(0, 15)), 1'($urandom), {$urandom, $urandom}, st);
      end
    join
    idle(4);
    for (int i = 0; i < 256; i++) chk("final_mem", mem[i], sh[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/ysyx_22040125_ram_arb.md
Name: ysyx_22040125_ram_arb

Overview:
- Two-port arbiter/controller in front of the single-port 64-bit data RAM.
- The RAM has a synchronous write and a registered read with 1-cycle latency.
- Shares the RAM between instruction fetch (m0, read-only) and load/store unit (m1, read/write).
- Executes LSU partial-strobe stores as read-modify-write sequences, because the RAM only supports full-word writes.

Parameters:
- ADDR_W, 32, word-address width (RAM word index, passed through unchanged)
- DATA_W, 64, data width; STRB_W = DATA_W/8 is derived internally

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_valid  in  1  IFU read request
- m0_ready  out  1  IFU request accepted when valid&&ready
- m0_addr  in  ADDR_W  IFU word address
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  DATA_W  IFU read data
- m1_valid  in  1  LSU request
- m1_ready  out  1  LSU request accepted when valid&&ready
- m1_addr  in  ADDR_W  LSU word address
- m1_we  in  1  1 = store, 0 = load
- m1_wdata  in  DATA_W  store data
- m1_wstrb  in  STRB_W  byte enables, bit i covers bits [8i+7:8i]
- m1_rvalid  out  1  one-cycle completion pulse, for loads and stores
- m1_rdata  out  DATA_W  load data; 0 on store completion
- ram_addr  out  32  to RAM address
- ram_wdata  out  DATA_W  to RAM write data
- ram_wen  out  1  to RAM write enable
- ram_rdata  in  DATA_W  from RAM registered read data

Behaviour:
- FSM states: IDLE, RD_RESP, RMW_MERGE, WR_RESP.
- Requests are accepted only in IDLE.
  - m*_ready is combinational: (state==IDLE) && grant && rst_n.
  - At most one ready is high per cycle.
- Arbitration in IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin; grant goes to the requester not granted at the last accept.
  - last_grant updates only on an accept.
  - Reset value of last_grant = m1, so m0 wins the first tie.
- In IDLE, ram_addr/ram_wdata are driven combinationally from the granted requester.
- In all other states they are driven from registered copies of addr, wdata, wstrb and the owner, captured at accept.
- Load/fetch: accept in IDLE with ram_wen=0 (RAM read issued) -> RD_RESP.
  - In RD_RESP the owner's rvalid=1 and rdata=ram_rdata, then -> IDLE.
  - Latency: rvalid 1 cycle after accept; one op per 2 cycles.
- Full store (wstrb all ones): accept in IDLE with ram_wen=1 and ram_wdata=m1_wdata -> WR_RESP.
  - WR_RESP: m1_rvalid=1, m1_rdata=0 -> IDLE.
- Partial store (wstrb neither all ones nor zero):
  - Accept with ram_wen=0 (read issued) -> RMW_MERGE.
  - RMW_MERGE: ram_wen=1, ram_wdata = per byte (wstrb ? wdata : ram_rdata) -> WR_RESP -> IDLE.
  - Completion pulse 2 cycles after accept.
- wstrb==0 store: accepted and ram_wen stays 0 -> WR_RESP (completion pulse, no RAM write).
- The RMW sequence is atomic: no other requester is granted between its read and write.
- Responses cannot be back-pressured; requesters must sink the rvalid pulse.
- rvalid is never asserted for the non-owner.
- Reset (any time, async):
  - State -> IDLE and registered copies -> 0.
  - rvalid outputs and ram_wen go 0 immediately.
  - An in-flight transaction is dropped with no response.
  - A RAM write committed on an earlier edge persists.
  - Ready stays 0 while rst_n=0.
- ram_wen is combinational from state and inputs; no glitch-sensitive consumers.

Optional Feature:
- Macro: YSYX_22040125_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, m1 (LSU) always wins when both are valid; last_grant logic is removed.
- Undefined: round-robin as specified above.

Test Plan:
- Preload ram[0x10]=0x1122334455667788; m0 read 0x10 -> m0_ready=1 at accept, m0_rvalid one cycle later with m0_rdata=0x1122334455667788, m1_rvalid stays 0.
- m1 full store 0x20 <- 0xDEADBEEFCAFEF00D, then m1 load 0x20 -> completion pulse one cycle after accept; load returns 0xDEADBEEFCAFEF00D.
- ram[0x30]=0xFFFFFFFFFFFFFFFF; m1 store wdata=0, wstrb=0x0F -> ram_wen only in RMW_MERGE, ram[0x30]=0xFFFFFFFF00000000, m1_rvalid 2 cycles after accept.
- m0 and m1 both valid continuously for 4 ops -> grants m0, m1, m0, m1 (macro undefined); with macro defined -> m1 on all 4 ops.
- m1 store with wstrb=0x00 to 0x40 (holding 0x55) -> ram_wen never asserted, m1_rvalid pulse, ram[0x40] still 0x55.
- Assert rst_n low during RMW_MERGE cycle -> ram_wen drops immediately, no m1_rvalid, RAM unchanged, next request accepted in first cycle after release.
